// File: rtl/cb_debounce.sv
// Per-bit debounce filter with registered rise/fall pulses and change flag.
// Define CB_DEBOUNCE_TICK_EN to add a tick_en prescaler strobe port.
module cb_debounce #(
    parameter int unsigned       U_DLY     = 1,
    parameter int unsigned       WIDTH     = 4,
    parameter int unsigned       CNT_W     = 16,
    parameter logic [CNT_W-1:0]  DB_CNT    = 16'd1000,
    parameter logic [WIDTH-1:0]  INT_VALUE = 4'h0
) (
    input  logic             clk_sys,
    input  logic             rst_n,
`ifdef CB_DEBOUNCE_TICK_EN
    input  logic             tick_en,
`endif
    input  logic [WIDTH-1:0] dat_in,
    output logic [WIDTH-1:0] dat_out,
    output logic [WIDTH-1:0] rise_pls,
    output logic [WIDTH-1:0] fall_pls,
    output logic             chg_any
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TOP = DB_CNT - CNT_ONE;

    // A zero threshold would make the counter compare against all-ones.
    if (DB_CNT == '0 || U_DLY > 32'd1000000) begin : g_bad_param
        $error("cb_debounce: DB_CNT must be 1..2^CNT_W-1");
    end

    logic                 qual;
    logic [CNT_W-1:0]     cnt_q [WIDTH];
    logic [CNT_W-1:0]     cnt_d [WIDTH];
    logic [WIDTH-1:0]     dat_q;
    logic [WIDTH-1:0]     dat_d;
    logic [WIDTH-1:0]     rise_q;
    logic [WIDTH-1:0]     rise_d;
    logic [WIDTH-1:0]     fall_q;
    logic [WIDTH-1:0]     fall_d;
    logic                 chg_q;
    logic                 chg_d;
    logic [WIDTH-1:0]     acc;

`ifdef CB_DEBOUNCE_TICK_EN
    assign qual = tick_en;
`else
    assign qual = 1'b1;
`endif

    always_comb begin
        dat_d = dat_q;
        acc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (qual) begin
                if (dat_in[i] == dat_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_TOP) begin
                    cnt_d[i] = '0;
                    dat_d[i] = dat_in[i];
                    acc[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        // Pulses only live for the edge that accepted the new level.
        rise_d = acc & dat_in;
        fall_d = acc & ~dat_in;
        chg_d  = |acc;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            dat_q  <= INT_VALUE;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dat_q  <= dat_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= chg_d;
        end
    end

    assign dat_out  = dat_q;
    assign rise_pls = rise_q;
    assign fall_pls = fall_q;
    assign chg_any  = chg_q;

endmodule

// File: tb/tb_cb_debounce.sv
// Bench for cb_debounce: three instances (DB_CNT 4, 1, 1000) against a
// sample-window model plus directed literal checks.
`timescale 1ns/1ps
module tb_cb_debounce;

    localparam int W = 4;
    localparam int unsigned NCNT [3] = '{4, 1, 1000};
    localparam logic [3:0]  INIT [3] = '{4'h0, 4'hA, 4'h0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] din  [3];
    logic [3:0] dout [3];
    logic [3:0] rise [3];
    logic [3:0] fall [3];
    logic       chg  [3];

    always #5 clk = ~clk;

`ifdef CB_DEBOUNCE_TICK_EN
    int   cyc = 0;
    logic tick_hold = 1'b0;
    initial tick = 1'b0;
    always @(negedge clk) begin
        cyc++;
        tick = !tick_hold && (cyc % 3 == 0);
    end
`else
    initial tick = 1'b1;
`endif

    cb_debounce #(.U_DLY(1), .WIDTH(4), .CNT_W(16), .DB_CNT(16'd4),
                  .INT_VALUE(4'h0)) u_db4 (
        .clk_sys(clk), .rst_n(rst_n),
`ifdef CB_DEBOUNCE_TICK_EN
        .tick_en(tick),
`endif
        .dat_in(din[0]), .dat_out(dout[0]), .rise_pls(rise[0]),
        .fall_pls(fall[0]), .chg_any(chg[0]));

    cb_debounce #(.U_DLY(1), .WIDTH(4), .CNT_W(16), .DB_CNT(16'd1),
                  .INT_VALUE(4'hA)) u_db1 (
        .clk_sys(clk), .rst_n(rst_n),
`ifdef CB_DEBOUNCE_TICK_EN
        .tick_en(tick),
`endif
        .dat_in(din[1]), .dat_out(dout[1]), .rise_pls(rise[1]),
        .fall_pls(fall[1]), .chg_any(chg[1]));

    cb_debounce #(.U_DLY(1), .WIDTH(4), .CNT_W(16), .DB_CNT(16'd1000),
                  .INT_VALUE(4'h0)) u_db1k (
        .clk_sys(clk), .rst_n(rst_n),
`ifdef CB_DEBOUNCE_TICK_EN
        .tick_en(tick),
`endif
        .dat_in(din[2]), .dat_out(dout[2]), .rise_pls(rise[2]),
        .fall_pls(fall[2]), .chg_any(chg[2]));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: a level is accepted once the last NCNT qualifying samples
    // all differ from the current filtered level.
    logic [3:0] hist [3][$];
    logic [3:0] m_out  [3];
    logic [3:0] m_rise [3];
    logic [3:0] m_fall [3];
    logic       m_chg  [3];

    function automatic void model_step(input int k);
        logic [3:0] acc;
        bit         all;
        acc = '0;
        if (!rst_n) begin
            hist[k].delete();
            m_out[k] = INIT[k];
        end else if (tick) begin
            hist[k].push_back(din[k]);
            if (hist[k].size() > int'(NCNT[k])) void'(hist[k].pop_front());
            if (hist[k].size() == int'(NCNT[k])) begin
                for (int i = 0; i < W; i++) begin
                    all = 1'b1;
                    for (int j = 0; j < hist[k].size(); j++)
                        if (hist[k][j][i] == m_out[k][i]) all = 1'b0;
                    acc[i] = all;
                end
            end
            m_out[k] = (m_out[k] & ~acc) | (din[k] & acc);
        end
        m_rise[k] = acc & din[k];
        m_fall[k] = acc & ~din[k];
        m_chg[k]  = |acc;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("model_u%0d", k),
                  {19'd0, dout[k], rise[k], fall[k], chg[k]},
                  {19'd0, m_out[k], m_rise[k], m_fall[k], m_chg[k]});
    end

    task automatic edges(input int n);
        for (int e = 0; e < n; e++) begin
            int guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!tick && guard < 50);
            if (!tick) begin
                n_chk++;
                $display("FAIL edges: no qualifying edge in %0d cycles", guard);
            end
        end
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        din[0] = 4'h0;
        din[1] = 4'hA;
        din[2] = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out4", dout[0], 4'h0);
        check("rst_out1", dout[1], 4'hA);
        check("rst_out1k", {dout[2], rise[2], fall[2], chg[2]}, 13'h0);

        @(negedge clk);
        rst_n = 1'b1;
        edges(999);
        check("1k_pre", dout[2], 4'h0);
        edges(1);
        check("1k_acc", {dout[2], rise[2], fall[2], chg[2]},
              {4'hF, 4'hF, 4'h0, 1'b1});
        next_cycle();
        check("1k_pls_end", {rise[2], chg[2]}, 5'h0);

        @(negedge clk);
        din[0] = 4'b0001;
        edges(3);
        check("clean_pre", dout[0], 4'b0000);
        edges(1);
        check("clean_acc", {dout[0], rise[0], fall[0], chg[0]},
              {4'b0001, 4'b0001, 4'b0000, 1'b1});
        next_cycle();
        check("clean_end", {rise[0], chg[0]}, 5'h0);

        @(negedge clk);
        din[0] = 4'b0011;
        edges(3);
        check("glitch_a", dout[0], 4'b0001);
        @(negedge clk);
        din[0] = 4'b0001;
        edges(1);
        @(negedge clk);
        din[0] = 4'b0011;
        edges(3);
        check("glitch_b", dout[0], 4'b0001);
        edges(1);
        check("glitch_acc", {dout[0], rise[0]}, {4'b0011, 4'b0010});

        @(negedge clk);
        din[0] = 4'b0111;
        edges(4);
        check("sim_setup", dout[0], 4'b0111);
        @(negedge clk);
        din[0] = 4'b1011;
        edges(3);
        check("sim_pre", {rise[0], fall[0]}, 8'h0);
        edges(1);
        check("sim_acc", {dout[0], rise[0], fall[0], chg[0]},
              {4'b1011, 4'b1000, 4'b0100, 1'b1});
        next_cycle();
        check("sim_end", chg[0], 1'b0);

        @(negedge clk);
        din[0] = 4'b1010;
        edges(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_4", {dout[0], rise[0], fall[0], chg[0]}, 13'h0);
        check("midrst_1", dout[1], 4'hA);
        @(negedge clk);
        rst_n = 1'b1;
        edges(3);
        check("midrst_pre", dout[0], 4'b0000);
        edges(1);
        check("midrst_acc", {dout[0], rise[0]}, {4'b1010, 4'b1010});

        @(negedge clk);
        din[1] = 4'h5;
        edges(1);
        check("db1_acc", {dout[1], rise[1], fall[1], chg[1]},
              {4'h5, 4'h5, 4'hA, 1'b1});

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) din[0] = 4'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                int b;
                b = $urandom_range(0, 3);
                din[0][b] = ~din[0][b];
            end
            din[1] = 4'($urandom);
            if ($urandom_range(0, 299) == 0) din[2] = 4'($urandom);
            rst_n = ($urandom_range(0, 599) != 0);
`ifdef CB_DEBOUNCE_TICK_EN
            if ($urandom_range(0, 99) == 0) tick_hold = ~tick_hold;
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
